// File: rtl/query_crc5_seq.sv
// ---------------------------------------------------------------------------
// query_crc5_seq : sequences the CRC5 datapath while a Gen2 Query frame arrives
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module query_crc5_seq #(
  parameter int CMD_BITS = 22,
  parameter int TIMEOUT  = 64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pkt_start,
  input  logic       i_bit_valid,
  input  logic       i_bit_in,
  input  logic       i_abort,
  input  logic [4:0] i_crc_residue,
  output logic       o_crc_reset,
  output logic       o_crc_shift,
  output logic       o_crc_bit,
  output logic       o_busy,
  output logic [4:0] o_bit_count,
  output logic       o_done,
  output logic       o_crc_ok,
  output logic       o_timeout_err
);

  localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]       C_MAX_BITS = 5'(CMD_BITS);
  localparam logic [4:0]       C_LAST_BIT = 5'(CMD_BITS - 1);
  localparam logic [GAP_W-1:0] C_GAP_MAX  = GAP_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESET  = 3'd1,
    S_COLLECT = 3'd2,
    S_SETTLE  = 3'd3,
    S_CHECK   = 3'd4,
    S_TOUT    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [4:0]       r_count;
  logic [4:0]       w_count_nxt;
  logic             r_crc_reset;
  logic             r_crc_shift;
  logic             r_crc_bit;
  logic             r_busy;
  logic             r_done;
  logic             r_crc_ok;
  logic             r_tout;
  logic             w_shift;
  logic             w_done;
  logic             w_tout;
  logic             w_ok_nxt;

  always_comb begin
    w_next      = r_state;
    w_gap_nxt   = r_gap;
    w_count_nxt = r_count;
    w_ok_nxt    = r_crc_ok;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_tout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_pkt_start) w_next = S_PRESET;
      end
      S_PRESET: begin
        w_next      = S_COLLECT;
        w_gap_nxt   = '0;
        w_count_nxt = '0;
        w_ok_nxt    = 1'b0;
      end
      S_COLLECT: begin
        if (i_pkt_start) begin
          w_next = S_PRESET;
        end else if (i_bit_valid) begin
          w_shift   = 1'b1;
          w_gap_nxt = '0;
          if (r_count != C_MAX_BITS) w_count_nxt = r_count + 5'd1;
          if (r_count == C_LAST_BIT) w_next = S_SETTLE;
        end else if (r_gap == C_GAP_MAX) begin
          w_next = S_TOUT;
          w_tout = 1'b1;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      S_SETTLE: begin
        w_next = i_pkt_start ? S_PRESET : S_CHECK;
      end
      S_CHECK: begin
        if (i_pkt_start) begin
          w_next = S_PRESET;
        end else begin
          w_next   = S_IDLE;
          w_done   = 1'b1;
          w_ok_nxt = (i_crc_residue == 5'b0);
        end
      end
      S_TOUT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Abort drops the frame outright, including anything decided above.
    if (i_abort) begin
      w_next      = S_IDLE;
      w_gap_nxt   = r_gap;
      w_count_nxt = r_count;
      w_ok_nxt    = r_crc_ok;
      w_shift     = 1'b0;
      w_done      = 1'b0;
      w_tout      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_count     <= '0;
      r_crc_reset <= 1'b1;
      r_crc_shift <= 1'b0;
      r_crc_bit   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_tout      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_gap       <= w_gap_nxt;
      r_count     <= w_count_nxt;
      r_crc_reset <= (w_next == S_IDLE) || (w_next == S_PRESET);
      r_crc_shift <= w_shift;
      r_crc_bit   <= w_shift & i_bit_in;
      r_busy      <= (w_next != S_IDLE);
      r_done      <= w_done;
      r_crc_ok    <= w_ok_nxt;
      r_tout      <= w_tout;
    end
  end

  assign o_crc_reset   = r_crc_reset;
  assign o_crc_shift   = r_crc_shift;
  assign o_crc_bit     = r_crc_bit;
  assign o_busy        = r_busy;
  assign o_bit_count   = r_count;
  assign o_done        = r_done;
  assign o_crc_ok      = r_crc_ok;
  assign o_timeout_err = r_tout;

endmodule

`default_nettype wire

// File: tb/tb_query_crc5_seq.sv
// ---------------------------------------------------------------------------
// tb_query_crc5_seq : scoreboard bench for query_crc5_seq with a CRC5 datapath
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_query_crc5_seq;

  localparam int NBITS = 22;
  localparam int TMO   = 64;

  logic       clk;
  logic       i_reset, i_pkt_start, i_bit_valid, i_bit_in, i_abort;
  logic [4:0] r_dp_crc;
  logic       o_crc_reset, o_crc_shift, o_crc_bit, o_busy;
  logic [4:0] o_bit_count;
  logic       o_done, o_crc_ok, o_timeout_err;

  typedef struct {
    bit is_tout;
    bit ok;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_cyc = 0;
  bit  busy_chk_pending = 0;

  query_crc5_seq #(.CMD_BITS(NBITS), .TIMEOUT(TMO)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_pkt_start   (i_pkt_start),
    .i_bit_valid   (i_bit_valid),
    .i_bit_in      (i_bit_in),
    .i_abort       (i_abort),
    .i_crc_residue (r_dp_crc),
    .o_crc_reset   (o_crc_reset),
    .o_crc_shift   (o_crc_shift),
    .o_crc_bit     (o_crc_bit),
    .o_busy        (o_busy),
    .o_bit_count   (o_bit_count),
    .o_done        (o_done),
    .o_crc_ok      (o_crc_ok),
    .o_timeout_err (o_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CRC5 shift register the sequencer drives (x^5+x^3+1, preset 01001)
  always @(posedge clk) begin
    if (o_crc_reset)      r_dp_crc <= 5'b01001;
    else if (o_crc_shift) r_dp_crc <= {r_dp_crc[3:0], 1'b0} ^ ((r_dp_crc[4] ^ o_crc_bit) ? 5'b01001 : 5'b0);
  end

  function automatic logic [4:0] crc5_of(input logic [16:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'b01001;
    for (int i = 16; i >= 0; i--) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b0);
    end
    return c;
  endfunction

  function automatic bit frame_ok(input logic [21:0] f);
    return crc5_of(f[21:5]) == f[4:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (busy_chk_pending) begin
      chk("busy_after_timeout", int'(o_busy), 0);
      busy_chk_pending = 0;
    end
    if (o_crc_shift) chk("shift_with_reset", int'(o_crc_reset), 0);
    if (o_done || o_timeout_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", int'({o_done, o_timeout_err}), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_is_timeout", int'(o_timeout_err), int'(mon_e.is_tout));
        chk("event_is_done", int'(o_done), int'(!mon_e.is_tout));
        chk("event_cycle", cyc, mon_e.cyc);
        if (mon_e.is_tout) begin
          chk("crc_ok_on_timeout", int'(o_crc_ok), 0);
          busy_chk_pending = 1;
        end else begin
          chk("crc_ok", int'(o_crc_ok), int'(mon_e.ok));
          chk("bit_count_at_done", int'(o_bit_count), NBITS);
          chk("residue_zero", int'(r_dp_crc == 5'b0), int'(mon_e.ok));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    i_pkt_start = 1'b1;
    tick();
    i_pkt_start = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [21:0] f, input int nb, input int sp, input bit push);
    ev_t e;
    int  idle;
    for (int i = 0; i < nb; i++) begin
      i_bit_valid = 1'b1;
      i_bit_in    = f[21-i];
      last_cyc    = cyc;
      if (push && i == NBITS - 1) begin
        e.is_tout = 1'b0;
        e.ok      = frame_ok(f);
        e.cyc     = cyc + 3;
        exp_q.push_back(e);
      end
      tick();
      i_bit_valid = 1'b0;
      i_bit_in    = 1'($urandom);
      idle = (sp < 0) ? int'($urandom_range(0, 4)) : sp;
      repeat (idle) tick();
    end
  endtask

  task automatic timeout_tail();
    ev_t e;
    e.is_tout = 1'b1;
    e.ok      = 1'b0;
    e.cyc     = last_cyc + 1 + TMO;
    exp_q.push_back(e);
    repeat (TMO + 6) tick();
  endtask

  task automatic do_abort();
    i_abort     = 1'b1;
    i_bit_valid = 1'($urandom);
    i_pkt_start = 1'($urandom);
    tick();
    i_abort     = 1'b0;
    i_bit_valid = 1'b0;
    i_pkt_start = 1'b0;
    chk("busy_after_abort", int'(o_busy), 0);
    chk("crc_reset_after_abort", int'(o_crc_reset), 1);
  endtask

  task automatic restart_with_bit();
    i_pkt_start = 1'b1;
    i_bit_valid = 1'b1;
    tick();
    i_pkt_start = 1'b0;
    i_bit_valid = 1'b0;
    tick();
  endtask

  task automatic settle_and_drain(input string name);
    repeat (5) tick();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [21:0] f;
    logic [16:0] d;
    int          kind, n;
    i_reset = 1'b1; i_pkt_start = 1'b0; i_bit_valid = 1'b0; i_bit_in = 1'b0; i_abort = 1'b0;
    repeat (3) tick();
    chk("reset_crc_reset", int'(o_crc_reset), 1);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_bit_count", int'(o_bit_count), 0);
    chk("reset_outputs", int'({o_crc_shift, o_done, o_crc_ok, o_timeout_err}), 0);
    i_reset = 1'b0;
    tick();
    chk("idle_crc_reset", int'(o_crc_reset), 1);

    // Valid frame, strobe every 4 clocks
    start_frame();
    chk("busy_in_frame", int'(o_busy), 1);
    send_bits(22'h200010, NBITS, 3, 1);
    settle_and_drain("pending_valid");

    // Corrupted frame
    start_frame();
    send_bits(22'h200011, NBITS, 3, 1);
    settle_and_drain("pending_corrupt");

    // Timeout after 10 bits
    start_frame();
    send_bits(22'h200010, 10, 3, 0);
    timeout_tail();
    chk("pending_timeout", exp_q.size(), 0);

    // Abort at bit 15, then a full valid frame
    start_frame();
    send_bits(22'h200010, 15, 3, 0);
    do_abort();
    chk("no_done_after_abort", int'(o_done | o_timeout_err), 0);
    tick();
    start_frame();
    send_bits(22'h200010, NBITS, 3, 1);
    settle_and_drain("pending_after_abort");

    // Restart at bit 8 with a simultaneous strobe
    start_frame();
    send_bits(22'h200010, 8, 3, 0);
    restart_with_bit();
    send_bits(22'h200010, NBITS, 3, 1);
    settle_and_drain("pending_restart");

    // Asynchronous reset between clock edges
    start_frame();
    send_bits(22'h200010, 5, 2, 0);
    #2 i_reset = 1'b1;
    #1;
    chk("async_busy", int'(o_busy), 0);
    chk("async_crc_reset", int'(o_crc_reset), 1);
    chk("async_bit_count", int'(o_bit_count), 0);
    tick();
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_bit_valid = 1'b1;
      i_bit_in    = 1'b1;
      tick();
      chk("idle_strobe_no_shift", int'(o_crc_shift), 0);
    end
    i_bit_valid = 1'b0;
    settle_and_drain("pending_after_reset");

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 4));
      d    = 17'($urandom);
      f    = {d, crc5_of(d)};
      if (kind == 1) f = f ^ (22'd1 << $urandom_range(0, 21));
      repeat ($urandom_range(0, 2)) begin
        i_bit_valid = 1'b1;
        tick();
        i_bit_valid = 1'b0;
      end
      start_frame();
      n = int'($urandom_range(1, NBITS - 1));
      case (kind)
        2: begin
          send_bits(f, n, -1, 0);
          timeout_tail();
        end
        3: begin
          send_bits(f, n, -1, 0);
          do_abort();
        end
        4: begin
          send_bits(f, n, -1, 0);
          restart_with_bit();
          send_bits(f, NBITS, -1, 1);
        end
        default: send_bits(f, NBITS, -1, 1);
      endcase
      repeat ($urandom_range(0, 2)) begin
        i_bit_valid = 1'b1;
        tick();
        i_bit_valid = 1'b0;
      end
      settle_and_drain("pending_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
